sga_input_conditioner: RTL and testbench
========================================

# sga_input_conditioner

Front-end stage of the Snake Game Arcade that turns raw board switches and push-buttons into clean, single-cycle events for the game control unit. It synchronises and debounces seven inputs: four direction buttons, start, restart and pause. It edge-detects them, keeps a one-entry buffer of the requested direction with a valid/ack handshake, and maintains the pause level. It sits directly upstream of the game top: its outputs replace the raw `buttons`, `start`, `restart` and `pause` nets.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before an input change is accepted; minimum 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clock` in 1: system clock. One clock domain; all logic on its rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `buttons_raw` in 4: raw direction buttons, active-high. Bit 3 left, 2 up, 1 down, 0 right.
- `start_raw`, `restart_raw`, `pause_raw` in 1 each: raw control inputs, active-high.
- `cur_direction` in 2: direction currently applied by the control unit.
- `dir_ack` in 1: control unit consumed `dir_req`.
- `buttons` out 4: debounced button levels.
- `dir_valid` out 1: a direction request is pending.
- `dir_req` out 2: pending direction. Encoding: 00 right, 01 down, 10 up, 11 left.
- `start_pulse`, `restart_pulse` out 1 each: one-cycle pulse on the debounced rising edge.
- `paused` out 1: pause level.

## Operation
- **Per-input path:** 2-FF synchroniser, then debouncer, then rising-edge detect.
- **Debouncer behaviour:**
  - Counter clears whenever the synchronised value equals the stable value.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES-1`, the stable value flips and the counter clears.
- **Direction press selection:** a rising edge on any direction button selects a candidate.
  - If several rise in the same cycle, priority is left > up > down > right.
  - Bit index i maps to encoding i, so right=0 … left=3.
  - Reverse of a direction d is `~d`.
- **Acceptance:** a candidate is accepted unless it equals `~cur_direction` (see Configuration) or equals `cur_direction`.
- **Buffer:** one entry, latest-wins.
  - Accepted candidate loads `dir_req` and sets `dir_valid`.
  - `dir_ack` while valid clears `dir_valid`; `dir_req` is retained.
  - `dir_ack` while not valid is ignored.
- **Simultaneous ack and accepted press:** the new value loads and `dir_valid` stays 1.
- **Pause:** `paused` toggles on each pause rising edge.
  - A restart rising edge forces `paused`=0, and this overrides a same-cycle pause edge.
  - The restart edge also clears `dir_valid`.
- **start_pulse:** issued regardless of `paused`.

## Timing
- **Reset values:** all synchronisers, stable values and counters are 0. `buttons`=0000, `dir_valid`=0, `dir_req`=00, `start_pulse`=0, `restart_pulse`=0, `paused`=0.
- **Reset mid-count:** the pending transition is discarded.
- **Latency, raw to stable:** a raw change held steady updates the debounced level `DEBOUNCE_CYCLES+2` edges after it is first sampled.
- **Latency, stable to registered outputs:** `start_pulse`, `restart_pulse`, `dir_valid` and `paused` update on the next edge, i.e. `DEBOUNCE_CYCLES+3` edges total.
- **Pulse width:** pulses are exactly 1 cycle.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- **Held button:** a held button yields one event only. A release must be debounced before the next press counts.
- **Handshake rules:**
  - `dir_req` is stable whenever `dir_valid`=1, except on a latest-wins overwrite.
  - `dir_ack` is sampled on the edge.
  - `dir_valid` falls the following cycle.

## Configuration
- **`SGA_REVERSAL_FILTER_EN`** controls rejection of reversal presses.
  - Defined: a candidate equal to `~cur_direction` is dropped. The buffer is unchanged and no `dir_valid` is set.
  - Undefined: reversals are accepted like any other direction, and the control unit's self-collision logic handles them.
  - Same-direction presses are dropped in both builds.

## Structure
- **Shared package `sga_pkg`:**
  - direction encodings `DIR_RIGHT`=2'b00, `DIR_DOWN`=2'b01, `DIR_UP`=2'b10, `DIR_LEFT`=2'b11;
  - typedef `dir_t` (logic [1:0]);
  - button bit-index constants.
- **Sub-module `sga_debounce`:** synchroniser + counter + stable register + rise output. Parameterised by `DEBOUNCE_CYCLES`; instantiated 7 times.
- **Top level:** priority select, reversal filter, direction buffer and pause flag.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- **Bounce rejection:** `buttons_raw[0]` toggles every 2 cycles for 20 cycles, then holds 1 → no event during the bouncing; `buttons`=0001 exactly 6 edges after the hold starts; a single `dir_valid` with `dir_req`=00 one cycle later.
- **Handshake overwrite:** `cur_direction`=00. Up press → `dir_req`=10, valid. Down press before ack → `dir_req`=01, valid stays 1. `dir_ack` → `dir_valid` 0 next cycle.
- **Reversal, filter defined:** `cur_direction`=00, left press → `dir_valid` stays 0. Without `SGA_REVERSAL_FILTER_EN`: `dir_req`=11, valid.
- **Simultaneous press:** up and right rise in the same cycle with `cur_direction`=11 → `dir_req`=10. The same-cycle `dir_ack` of an older request still leaves valid=1.
- **Pause and restart:** pause press → `paused`=1; second pause press → 0. Pause and restart edges in the same cycle while paused=1 → `paused`=0, one-cycle `restart_pulse`, `dir_valid` cleared.
- **Reset mid-count:** `start_raw` held 1, `reset_n` asserted at count 2 → all outputs 0. After release with `start_raw` still 1 → `start_pulse` 7 edges after release.

Source files
------------

// File: rtl/sga_pkg.sv
// Shared Snake Game Arcade definitions: direction encoding, button bit positions.
// The reverse of a direction is its bitwise complement.
package sga_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_UP    = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_LEFT  = 3;

  function automatic dir_t dir_reverse(input dir_t d);
    return ~d;
  endfunction

endpackage

// File: rtl/sga_debounce.sv
// One raw input: 2-FF synchroniser, stability counter, debounced level and a one-cycle rise flag.
// Level changes DEBOUNCE_CYCLES+2 edges after a steady raw change is sampled; no backpressure.
module sga_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      rise_d   = ~stable_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sga_input_conditioner.sv
// Debounced buttons -> one-entry latest-wins direction buffer, start/restart pulses, pause flag.
// Registered outputs follow debounced edges by one cycle; SGA_REVERSAL_FILTER_EN drops reversal presses.
module sga_input_conditioner
  import sga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] buttons_raw,
  input  logic       start_raw,
  input  logic       restart_raw,
  input  logic       pause_raw,
  input  dir_t       cur_direction,
  input  logic       dir_ack,
  output logic [3:0] buttons,
  output logic       dir_valid,
  output dir_t       dir_req,
  output logic       start_pulse,
  output logic       restart_pulse,
  output logic       paused
);

  // Bits 3:0 buttons, 4 start, 5 restart, 6 pause
  logic [6:0] raw_vec, level_vec, rise_vec;
  logic [2:0] ctrl_level_unused;

  assign raw_vec = {pause_raw, restart_raw, start_raw, buttons_raw};

  for (genvar i = 0; i < 7; i++) begin : g_deb
    sga_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (raw_vec[i]),
      .level  (level_vec[i]),
      .rise   (rise_vec[i])
    );
  end

  assign buttons           = level_vec[3:0];
  assign ctrl_level_unused = level_vec[6:4];

  logic       start_rise, restart_rise, pause_rise;
  logic [3:0] btn_rise;
  assign btn_rise     = rise_vec[3:0];
  assign start_rise   = rise_vec[4];
  assign restart_rise = rise_vec[5];
  assign pause_rise   = rise_vec[6];

  dir_t cand;
  logic is_rev, accept;

  always_comb begin
    cand = DIR_RIGHT;
    if (btn_rise[BTN_LEFT])      cand = DIR_LEFT;
    else if (btn_rise[BTN_UP])   cand = DIR_UP;
    else if (btn_rise[BTN_DOWN]) cand = DIR_DOWN;
`ifdef SGA_REVERSAL_FILTER_EN
    is_rev = (cand == dir_reverse(cur_direction));
`else
    is_rev = 1'b0;
`endif
    accept = (|btn_rise) && (cand != cur_direction) && !is_rev;
  end

  logic dir_valid_q, dir_valid_d;
  dir_t dir_req_q, dir_req_d;
  logic paused_q, paused_d;
  logic start_pulse_q, restart_pulse_q;

  // Restart wins over everything; an accepted press wins over a same-cycle ack.
  always_comb begin
    dir_valid_d = dir_valid_q;
    dir_req_d   = dir_req_q;
    paused_d    = paused_q;
    if (restart_rise) begin
      dir_valid_d = 1'b0;
    end else if (accept) begin
      dir_valid_d = 1'b1;
      dir_req_d   = cand;
    end else if (dir_ack) begin
      dir_valid_d = 1'b0;
    end
    if (restart_rise)    paused_d = 1'b0;
    else if (pause_rise) paused_d = ~paused_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dir_valid_q     <= 1'b0;
      dir_req_q       <= DIR_RIGHT;
      paused_q        <= 1'b0;
      start_pulse_q   <= 1'b0;
      restart_pulse_q <= 1'b0;
    end else begin
      dir_valid_q     <= dir_valid_d;
      dir_req_q       <= dir_req_d;
      paused_q        <= paused_d;
      start_pulse_q   <= start_rise;
      restart_pulse_q <= restart_rise;
    end
  end

  assign dir_valid     = dir_valid_q;
  assign dir_req       = dir_req_q;
  assign paused        = paused_q;
  assign start_pulse   = start_pulse_q;
  assign restart_pulse = restart_pulse_q;

endmodule

// File: tb/tb_sga_input_conditioner.sv
// Directed test-plan steps followed by randomized clean presses checked against a press-level model.
module tb_sga_input_conditioner;
  import sga_pkg::*;

  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] buttons_raw = 4'b0;
  logic       start_raw = 1'b0, restart_raw = 1'b0, pause_raw = 1'b0;
  dir_t       cur_direction = DIR_DOWN;
  logic       dir_ack = 1'b0;
  logic [3:0] buttons;
  logic       dir_valid;
  dir_t       dir_req;
  logic       start_pulse, restart_pulse, paused;

  int checks = 0;
  int failures = 0;

  sga_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .buttons_raw  (buttons_raw),
    .start_raw    (start_raw),
    .restart_raw  (restart_raw),
    .pause_raw    (pause_raw),
    .cur_direction(cur_direction),
    .dir_ack      (dir_ack),
    .buttons      (buttons),
    .dir_valid    (dir_valid),
    .dir_req      (dir_req),
    .start_pulse  (start_pulse),
    .restart_pulse(restart_pulse),
    .paused       (paused)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Raw press held steady; ack (if any) is presented on the edge where the press takes effect.
  task automatic press(input logic [3:0] mask, input logic ack);
    buttons_raw = mask;
    ticks(DC + 2);
    dir_ack = ack;
    tick();
    dir_ack = 1'b0;
  endtask

  task automatic release_btns();
    buttons_raw = 4'b0;
    ticks(DC + 4);
  endtask

  task automatic ack_once();
    dir_ack = 1'b1;
    tick();
    dir_ack = 1'b0;
  endtask

  logic [7:0] all_out;
  assign all_out = {buttons, dir_valid, start_pulse, restart_pulse, paused} ^ {6'b0, dir_req};

  logic       m_valid;
  dir_t       m_req;
  dir_t       cand;
  logic [3:0] mask;
  logic       ack, acc;

  initial begin
    // Reset state
    ticks(3);
    chk("reset_outputs", {buttons, dir_valid, start_pulse, restart_pulse, paused, 1'b0}, 8'h00);
    chk("reset_dir_req", 8'(dir_req), 8'h00);
    reset_n = 1'b1;
    tick();

    // Bounce rejection, cur_direction=down so a right press is acceptable
    cur_direction = DIR_DOWN;
    for (int i = 0; i < 20; i++) begin
      buttons_raw = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      chk("bounce_quiet", {3'b0, buttons, dir_valid}, 8'h00);
    end
    buttons_raw = 4'b0001;
    ticks(5);
    chk("hold_edge5_buttons", 8'(buttons), 8'h00);
    tick();
    chk("hold_edge6_buttons", 8'(buttons), 8'h01);
    chk("hold_edge6_valid", 8'(dir_valid), 8'h00);
    tick();
    chk("hold_edge7_valid", 8'(dir_valid), 8'h01);
    chk("hold_edge7_req", 8'(dir_req), 8'h00);
    ack_once();
    chk("hold_ack_valid", 8'(dir_valid), 8'h00);
    ticks(4);
    chk("held_single_event", 8'(dir_valid), 8'h00);
    release_btns();
    chk("release_no_event", 8'(dir_valid), 8'h00);

    // Handshake overwrite
    cur_direction = DIR_RIGHT;
    press(4'b0100, 1'b0);
    chk("ovr_up_valid", 8'(dir_valid), 8'h01);
    chk("ovr_up_req", 8'(dir_req), 8'h02);
    release_btns();
    press(4'b0010, 1'b0);
    chk("ovr_down_valid", 8'(dir_valid), 8'h01);
    chk("ovr_down_req", 8'(dir_req), 8'h01);
    release_btns();
    ack_once();
    chk("ovr_ack_valid", 8'(dir_valid), 8'h00);
    chk("ovr_ack_req_kept", 8'(dir_req), 8'h01);
    ack_once();
    chk("ack_when_idle", 8'(dir_valid), 8'h00);

    // Reversal and same-direction presses
    press(4'b1000, 1'b0);
`ifdef SGA_REVERSAL_FILTER_EN
    chk("reversal_valid", 8'(dir_valid), 8'h00);
    chk("reversal_req_kept", 8'(dir_req), 8'h01);
`else
    chk("reversal_valid", 8'(dir_valid), 8'h01);
    chk("reversal_req", 8'(dir_req), 8'h03);
`endif
    release_btns();
    ack_once();
    press(4'b0001, 1'b0);
    chk("same_dir_dropped", 8'(dir_valid), 8'h00);
    release_btns();

    // Simultaneous press with same-cycle ack of an older request
    cur_direction = DIR_LEFT;
    press(4'b0010, 1'b0);
    chk("simul_old_req", 8'(dir_req), 8'h01);
    release_btns();
    press(4'b0101, 1'b1);
    chk("simul_valid", 8'(dir_valid), 8'h01);
    chk("simul_req", 8'(dir_req), 8'h02);
    release_btns();
    ack_once();

    // Pause toggling, then pause+restart together
    for (int p = 0; p < 3; p++) begin
      pause_raw = 1'b1;
      ticks(DC + 2);
      chk("pause_before", 8'(paused), 8'(p % 2));
      tick();
      chk("pause_after", 8'(paused), 8'((p + 1) % 2));
      pause_raw = 1'b0;
      ticks(DC + 4);
    end
    cur_direction = DIR_RIGHT;
    press(4'b0100, 1'b0);
    chk("pre_restart_valid", 8'(dir_valid), 8'h01);
    release_btns();
    pause_raw = 1'b1;
    restart_raw = 1'b1;
    ticks(DC + 2);
    chk("restart_pulse_early", 8'(restart_pulse), 8'h00);
    tick();
    chk("restart_paused", 8'(paused), 8'h00);
    chk("restart_pulse", 8'(restart_pulse), 8'h01);
    chk("restart_valid", 8'(dir_valid), 8'h00);
    chk("restart_no_start", 8'(start_pulse), 8'h00);
    tick();
    chk("restart_pulse_width", 8'(restart_pulse), 8'h00);
    pause_raw = 1'b0;
    restart_raw = 1'b0;
    ticks(DC + 4);

    // Reset mid-count
    start_raw = 1'b1;
    ticks(4);
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", all_out, 8'h00);
    ticks(2);
    reset_n = 1'b1;
    ticks(6);
    chk("start_pulse_edge6", 8'(start_pulse), 8'h00);
    tick();
    chk("start_pulse_edge7", 8'(start_pulse), 8'h01);
    tick();
    chk("start_pulse_width", 8'(start_pulse), 8'h00);
    start_raw = 1'b0;
    ticks(DC + 4);

    // Randomized clean presses against a press-level model
    m_valid = 1'b0;
    m_req   = DIR_RIGHT;
    for (int n = 0; n < 40; n++) begin
      cur_direction = 2'($urandom_range(0, 3));
      mask          = 4'($urandom_range(1, 15));
      ack           = 1'($urandom_range(0, 1));
      cand = DIR_RIGHT;
      for (int b = 0; b < 4; b++) if (mask[b]) cand = 2'(b);
      acc = (cand != cur_direction);
`ifdef SGA_REVERSAL_FILTER_EN
      if (cand == ~cur_direction) acc = 1'b0;
`endif
      if (acc) begin
        m_valid = 1'b1;
        m_req   = cand;
      end else if (ack) begin
        m_valid = 1'b0;
      end
      press(mask, ack);
      chk("rand_buttons", 8'(buttons), 8'(mask));
      chk("rand_valid", 8'(dir_valid), 8'(m_valid));
      chk("rand_req", 8'(dir_req), 8'(m_req));
      release_btns();
      if ($urandom_range(0, 1) == 1) begin
        ack_once();
        m_valid = 1'b0;
        chk("rand_ack_valid", 8'(dir_valid), 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
